// File: rtl/u_rec_param.sv
// Parametrised UART receiver: 2-flop synchroniser, centre-sampling FSM and a valid/ack output register.
// Optional parity bit is built in when UART_REC_PARITY_EN is defined.
module u_rec_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_dataH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_validH,
  input  logic                 rec_ackH,
  output logic                 frame_errH,
  output logic                 parity_errH,
  output logic                 overrunH
);

  localparam int CW = $clog2(OVERSAMPLE);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("u_rec_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state, state_d;
  logic                 sync1, rec_datH;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 frm_acc;
  logic                 par_acc;
  logic                 dlv;
  logic                 centre;
  logic                 last_stop;

  assign centre = (state == START) ? (cnt == CW'(OVERSAMPLE/2 - 1)) : (cnt == CW'(OVERSAMPLE - 1));

  always_comb begin
    state_d   = state;
    last_stop = 1'b0;
    case (state)
      IDLE:   if (!rec_datH) state_d = START;
      START:  if (centre) state_d = rec_datH ? IDLE : DATA;
      DATA:   if (centre && bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_REC_PARITY_EN
        state_d = PARITY;
`else
        state_d = STOP;
`endif
      end
      PARITY: if (centre) state_d = STOP;
      STOP:   if (centre && bit_cnt == 4'(STOP_BITS - 1)) begin
        last_stop = 1'b1;
        state_d   = rec_datH ? IDLE : BREAK;
      end
      BREAK:  if (rec_datH) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1      <= 1'b1;
      rec_datH   <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frm_acc    <= 1'b0;
      dlv        <= 1'b0;
      rec_dataH  <= '0;
      rec_validH <= 1'b0;
      frame_errH <= 1'b0;
      overrunH   <= 1'b0;
    end else begin
      sync1    <= uart_dataH;
      rec_datH <= sync1;
      state    <= state_d;
      dlv      <= last_stop;

      // Re-phase the cell counter at the start edge and again at the start-bit centre,
      // so every later centre lands one full cell after the previous one.
      if ((state != START && state_d == START) || (state == START && centre))
        cnt <= '0;
      else if (cnt == CW'(OVERSAMPLE - 1))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != state_d)
        bit_cnt <= '0;
      else if (centre && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 1'b1;

      if (state == START)
        frm_acc <= 1'b0;
      else if (state == STOP && centre && !rec_datH)
        frm_acc <= 1'b1;

      if (state == DATA && centre)
        shift <= {rec_datH, shift[DATA_BITS-1:1]};

      if (rec_validH && rec_ackH) begin
        rec_validH <= 1'b0;
        frame_errH <= 1'b0;
        overrunH   <= 1'b0;
      end
      // A delivery overrides the ack clear; an un-acked word blocks the new one.
      if (dlv) begin
        if (rec_validH && !rec_ackH) begin
          overrunH <= 1'b1;
        end else begin
          rec_dataH  <= shift;
          frame_errH <= frm_acc;
          rec_validH <= 1'b1;
        end
      end
    end
  end

`ifdef UART_REC_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      par_acc     <= 1'b0;
      parity_errH <= 1'b0;
    end else begin
      if (state == START)
        par_acc <= 1'b0;
      else if (state == PARITY && centre)
        par_acc <= rec_datH ^ (^shift) ^ PARITY_ODD[0];

      if (rec_validH && rec_ackH)
        parity_errH <= 1'b0;
      if (dlv && !(rec_validH && !rec_ackH))
        parity_errH <= par_acc;
    end
  end
`else
  assign par_acc     = 1'b0;
  assign parity_errH = par_acc;
`endif

endmodule

// File: tb/tb_u_rec_param.sv
// Self-checking bench for u_rec_param (8 data bits, x16, 1 stop bit): directed scenarios plus
// randomised frames checked against a frame-level reference model.
module tb_u_rec_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 1;
`ifdef UART_REC_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + OS/2 + (DB + P + SB)*OS + 1;
  localparam int W   = DB + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart = 1'b1;
  logic          ack = 1'b0;
  logic [DB-1:0] rec_data;
  logic          rec_valid, frame_err, parity_err, overrun;

  u_rec_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .uart_dataH (uart),
    .rec_dataH  (rec_data),
    .rec_validH (rec_valid),
    .rec_ackH   (ack),
    .frame_errH (frame_err),
    .parity_errH(parity_err),
    .overrunH   (overrun)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // monitor: log every newly presented word with its arrival cycle
  logic [W-1:0] got_q[$];
  int           got_t[$];
  logic [W-1:0] exp_q[$];
  logic         pv_s = 1'b0, pa_s = 1'b0;
  int           valid_cycles = 0;
  always @(posedge clk) begin
    pv_s <= rec_valid;
    pa_s <= ack;
  end
  always @(negedge clk) begin
    if (rec_valid) valid_cycles++;
    if (!rst && rec_valid && (!pv_s || pa_s)) begin
      got_q.push_back({parity_err, frame_err, rec_data});
      got_t.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // reference model: what a frame should report, derived from the line bits
  function automatic logic [W-1:0] model(input logic [DB-1:0] d, input logic par_flip, input logic stop_v);
    logic pe;
    pe = (P == 1) ? par_flip : 1'b0;
    return {pe, ~stop_v, d};
  endfunction

  // driver tasks (called at a negedge)
  task automatic drive_bit(input logic v);
    uart = v;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par_flip, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (P == 1) drive_bit((^d) ^ par_flip);
    for (int i = 0; i < SB; i++) drive_bit(stop_v);
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rec_valid); end
    checks++; if (rec_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=00", rec_data); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {frame_err, parity_err, overrun}); end
    checks++; if (int'(dut.state) !== 0) begin errors++; $display("FAIL reset_state got=%0d want=0", int'(dut.state)); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_latency();
    int t0, v0;
    ack = 1'b1;
    clear_logs();
    v0 = valid_cycles;
    t0 = cyc + 1;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL lat_count got=%0d want=1", got_q.size());
    end else begin
      if (got_q[0] !== model(8'hA5, 1'b0, 1'b1)) begin errors++; $display("FAIL lat_word got=%h want=%h", got_q[0], model(8'hA5, 1'b0, 1'b1)); end
      checks++;
      if (got_t[0] !== t0 + LAT) begin errors++; $display("FAIL lat_cycle got=%0d want=%0d", got_t[0] - t0, LAT); end
    end
    checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL lat_pulse got=%0d want=1", valid_cycles - v0); end
  endtask

  task automatic test_glitch();
    int t0;
    ack = 1'b1;
    clear_logs();
    t0 = cyc + 1;
    uart = 1'b0;
    repeat (3) @(negedge clk);
    uart = 1'b1;
    while (cyc < t0 + 5) @(negedge clk);
    checks++; if (int'(dut.state) !== 1) begin errors++; $display("FAIL glitch_start got=%0d want=1", int'(dut.state)); end
    while (cyc < t0 + 11) @(negedge clk);
    checks++; if (int'(dut.state) !== 0) begin errors++; $display("FAIL glitch_idle got=%0d want=0", int'(dut.state)); end
    repeat (200) @(negedge clk);
    checks++; if (got_q.size() !== 0 || rec_valid !== 1'b0) begin errors++; $display("FAIL glitch_word got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_break();
    ack = 1'b1;
    clear_logs();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (int'(dut.state) !== 5) begin errors++; $display("FAIL break_state got=%0d want=5", int'(dut.state)); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL break_count got=%0d want=1", got_q.size()); end
    else if (got_q[0] !== model(8'h3C, 1'b0, 1'b0)) begin errors++; $display("FAIL break_word got=%h want=%h", got_q[0], model(8'h3C, 1'b0, 1'b0)); end
    clear_logs();
    uart = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (got_q.size() !== 0 || int'(dut.state) !== 0) begin errors++; $display("FAIL break_exit words=%0d state=%0d want 0/0", got_q.size(), int'(dut.state)); end
  endtask

  task automatic test_overrun();
    ack = 1'b0;
    clear_logs();
    send_frame(8'h11, 1'b0, 1'b1);
    checks++; if (overrun !== 1'b0 || rec_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got v=%b o=%b want v=1 o=0", rec_valid, overrun); end
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (rec_data !== 8'h11) begin errors++; $display("FAIL ovr_data got=%h want=11", rec_data); end
    checks++; if (overrun !== 1'b1 || rec_valid !== 1'b1) begin errors++; $display("FAIL ovr_flag got v=%b o=%b want 1/1", rec_valid, overrun); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ovr_count got=%0d want=1", got_q.size()); end
    ack = 1'b1;
    @(negedge clk);
    checks++; if ({rec_valid, frame_err, parity_err, overrun} !== 4'b0000) begin errors++; $display("FAIL ovr_ack got=%b want=0000", {rec_valid, frame_err, parity_err, overrun}); end
    ack = 1'b0;
  endtask

`ifdef UART_REC_PARITY_EN
  task automatic test_parity();
    ack = 1'b0;
    clear_logs();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (parity_err !== 1'b1 || rec_data !== 8'h07) begin errors++; $display("FAIL parity_err got pe=%b d=%h want 1/07", parity_err, rec_data); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    ack = 1'b0;
    clear_logs();
    send_frame(8'h77, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rec_valid !== 1'b1 || rec_data !== 8'h77) begin errors++; $display("FAIL rstmid_pre got v=%b d=%h want 1/77", rec_valid, rec_data); end
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    repeat (OS/2) @(negedge clk);
    rst = 1'b1;
    uart = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({rec_valid, frame_err, parity_err, overrun} !== 4'b0000 || rec_data !== '0) begin errors++; $display("FAIL rstmid_out got=%b d=%h want 0000/00", {rec_valid, frame_err, parity_err, overrun}, rec_data); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    clear_logs();
    ack = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count got=%0d want=1", got_q.size()); end
    else if (got_q[0] !== model(8'h5A, 1'b0, 1'b1)) begin errors++; $display("FAIL rstmid_word got=%h want=%h", got_q[0], model(8'h5A, 1'b0, 1'b1)); end
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic          pf, sv, late_ack;
    logic [W-1:0]  g, e;
    clear_logs();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      d        = DB'($urandom);
      pf       = (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      sv       = ($urandom_range(0, 3) != 0);
      late_ack = 1'($urandom_range(0, 1));
      ack      = ~late_ack;
      repeat ($urandom_range(2, 20)) @(negedge clk);
      exp_q.push_back(model(d, pf, sv));
      send_frame(d, pf, sv);
      if (!sv) repeat ($urandom_range(0, 30)) @(negedge clk);
      uart = 1'b1;
      if (late_ack) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        checks++; if (rec_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rand_ack n=%0d got v=%b o=%b want 0/0", n, rec_valid, overrun); end
      end
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL rand_missing n=%0d got=none want=%h", n, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL rand_word n=%0d got=%h want=%h", n, g, e); end
      end
    end
    repeat (40) @(negedge clk);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rand_extra got=%0d want=0", got_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_break();
    test_overrun();
`ifdef UART_REC_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
